// File: rtl/avalon_bus_arbiter.sv
// Two-master, one-slave Avalon-MM arbiter: whole-transfer grants with round-robin
// tie breaking, and an abort path for transfers the slave stalls indefinitely.
module avalon_bus_arbiter #(
    parameter int          TIMEOUT_CYCLES = 256,
    parameter logic [31:0] ABORT_RDATA    = 32'hFFFFFFFF
) (
    input  logic        clk,
    input  logic        reset,

    input  logic [31:0] m0_address,
    input  logic        m0_read,
    input  logic        m0_write,
    input  logic [31:0] m0_writedata,
    input  logic [3:0]  m0_byteenable,
    output logic [31:0] m0_readdata,
    output logic        m0_waitrequest,

    input  logic [31:0] m1_address,
    input  logic        m1_read,
    input  logic        m1_write,
    input  logic [31:0] m1_writedata,
    input  logic [3:0]  m1_byteenable,
    output logic [31:0] m1_readdata,
    output logic        m1_waitrequest,

    output logic [31:0] s_address,
    output logic        s_read,
    output logic        s_write,
    output logic [31:0] s_writedata,
    output logic [3:0]  s_byteenable,
    input  logic [31:0] s_readdata,
    input  logic        s_waitrequest,

    output logic [1:0]  grant,
    output logic        bus_timeout
);

    localparam int               CNT_W    = $clog2(TIMEOUT_CYCLES) + 1;
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT_CYCLES - 1);

    typedef enum logic [2:0] {
        IDLE,
        OWN0,
        OWN1,
        ABORT0,
        ABORT1
    } state_t;

    state_t           state;
    logic             last_owner;
    logic [CNT_W-1:0] stall_cnt;
    logic             req0;
    logic             req1;
    logic             cur_req;

    assign req0    = m0_read | m0_write;
    assign req1    = m1_read | m1_write;
    assign cur_req = (state == OWN1) ? req1 : req0;

    // last_owner = 1 means m1 finished last, so m0 wins the next tie
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state       <= IDLE;
            last_owner  <= 1'b1;
            stall_cnt   <= '0;
            bus_timeout <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    stall_cnt <= '0;
                    if (req0 && (!req1 || last_owner)) begin
                        state <= OWN0;
                    end else if (req1) begin
                        state <= OWN1;
                    end
                end
                OWN0, OWN1: begin
                    if (!cur_req) begin
                        state     <= IDLE;
                        stall_cnt <= '0;
                    end else if (!s_waitrequest) begin
                        state      <= IDLE;
                        last_owner <= (state == OWN1);
                        stall_cnt  <= '0;
                    end else if (stall_cnt == CNT_LAST) begin
                        state     <= (state == OWN1) ? ABORT1 : ABORT0;
                        stall_cnt <= '0;
                    end else begin
                        stall_cnt <= stall_cnt + CNT_W'(1);
                    end
                end
                ABORT0: begin
                    state       <= IDLE;
                    last_owner  <= 1'b0;
                    bus_timeout <= 1'b1;
                end
                ABORT1: begin
                    state       <= IDLE;
                    last_owner  <= 1'b1;
                    bus_timeout <= 1'b1;
                end
                default: state <= IDLE;
            endcase
        end
    end

    // Bus steering is decoded from state so reset silences the slave immediately
    always_comb begin
        s_address      = '0;
        s_read         = 1'b0;
        s_write        = 1'b0;
        s_writedata    = '0;
        s_byteenable   = '0;
        m0_readdata    = '0;
        m1_readdata    = '0;
        m0_waitrequest = 1'b1;
        m1_waitrequest = 1'b1;
        grant          = 2'b00;
        case (state)
            IDLE: begin
                m0_waitrequest = req0;
                m1_waitrequest = req1;
            end
            OWN0: begin
                s_address      = m0_address;
                s_read         = m0_read & ~m0_write;
                s_write        = m0_write;
                s_writedata    = m0_writedata;
                s_byteenable   = m0_byteenable;
                m0_waitrequest = s_waitrequest;
                m0_readdata    = s_readdata;
                grant          = 2'b01;
            end
            OWN1: begin
                s_address      = m1_address;
                s_read         = m1_read & ~m1_write;
                s_write        = m1_write;
                s_writedata    = m1_writedata;
                s_byteenable   = m1_byteenable;
                m1_waitrequest = s_waitrequest;
                m1_readdata    = s_readdata;
                grant          = 2'b10;
            end
            ABORT0: begin
                m0_waitrequest = 1'b0;
                m0_readdata    = ABORT_RDATA;
                grant          = 2'b01;
            end
            ABORT1: begin
                m1_waitrequest = 1'b0;
                m1_readdata    = ABORT_RDATA;
                grant          = 2'b10;
            end
            default: ;
        endcase
    end

endmodule

// File: tb/tb_avalon_bus_arbiter.sv
// Bench for avalon_bus_arbiter: directed scenarios followed by random traffic,
// all compared against a transaction-level model of ownership and timeouts.
module tb_avalon_bus_arbiter;

    localparam int          TIMEOUT = 8;
    localparam logic [31:0] ABORT   = 32'hFFFFFFFF;

    logic        clk = 1'b0;
    logic        reset;
    logic [31:0] m0_address, m0_writedata, m0_readdata;
    logic        m0_read, m0_write, m0_waitrequest;
    logic [3:0]  m0_byteenable;
    logic [31:0] m1_address, m1_writedata, m1_readdata;
    logic        m1_read, m1_write, m1_waitrequest;
    logic [3:0]  m1_byteenable;
    logic [31:0] s_address, s_writedata, s_readdata;
    logic        s_read, s_write, s_waitrequest;
    logic [3:0]  s_byteenable;
    logic [1:0]  grant;
    logic        bus_timeout;

    always #5 clk = ~clk;

    avalon_bus_arbiter #(.TIMEOUT_CYCLES(TIMEOUT), .ABORT_RDATA(ABORT)) dut (
        .clk(clk), .reset(reset),
        .m0_address(m0_address), .m0_read(m0_read), .m0_write(m0_write),
        .m0_writedata(m0_writedata), .m0_byteenable(m0_byteenable),
        .m0_readdata(m0_readdata), .m0_waitrequest(m0_waitrequest),
        .m1_address(m1_address), .m1_read(m1_read), .m1_write(m1_write),
        .m1_writedata(m1_writedata), .m1_byteenable(m1_byteenable),
        .m1_readdata(m1_readdata), .m1_waitrequest(m1_waitrequest),
        .s_address(s_address), .s_read(s_read), .s_write(s_write),
        .s_writedata(s_writedata), .s_byteenable(s_byteenable),
        .s_readdata(s_readdata), .s_waitrequest(s_waitrequest),
        .grant(grant), .bus_timeout(bus_timeout)
    );

    int checks = 0;
    int failures = 0;

    // Model: who owns the slave (-1 none), whether that ownership is being aborted,
    // stalls seen so far, who finished last, and the sticky timeout flag
    int   mOwner;
    bit   mAbort;
    int   mStall;
    int   mLast;
    bit   mSticky;
    logic expW0, expW1;

    logic [1:0] altGrant [6] = '{2'b00, 2'b01, 2'b00, 2'b10, 2'b00, 2'b01};

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("[TB] FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic modelReset();
        mOwner  = -1;
        mAbort  = 1'b0;
        mStall  = 0;
        mLast   = 1;
        mSticky = 1'b0;
    endtask

    task automatic applyStimulus(input int op0, input logic [31:0] a0, input logic [31:0] d0,
                                 input logic [3:0] b0, input int op1, input logic [31:0] a1,
                                 input logic [31:0] d1, input logic [3:0] b1,
                                 input logic sw, input logic [31:0] srd);
        m0_read       = (op0 == 1);
        m0_write      = (op0 == 2);
        m0_address    = a0;
        m0_writedata  = d0;
        m0_byteenable = b0;
        m1_read       = (op1 == 1);
        m1_write      = (op1 == 2);
        m1_address    = a1;
        m1_writedata  = d1;
        m1_byteenable = b1;
        s_waitrequest = sw;
        s_readdata    = srd;
    endtask

    task automatic checkAll(input string tag);
        logic [31:0] eAddr, eWd, eRd0, eRd1;
        logic [3:0]  eBe;
        logic        eRd, eWr, eW0, eW1;
        logic [1:0]  eGrant;
        eAddr = '0; eWd = '0; eBe = '0; eRd = 1'b0; eWr = 1'b0;
        eRd0 = '0; eRd1 = '0; eW0 = 1'b1; eW1 = 1'b1; eGrant = 2'b00;
        if (mOwner < 0) begin
            eW0 = m0_read | m0_write;
            eW1 = m1_read | m1_write;
        end else if (mAbort) begin
            if (mOwner == 0) begin eW0 = 1'b0; eRd0 = ABORT; end
            else begin eW1 = 1'b0; eRd1 = ABORT; end
        end else if (mOwner == 0) begin
            eAddr = m0_address; eWd = m0_writedata; eBe = m0_byteenable;
            eWr = m0_write; eRd = m0_read && !m0_write;
            eW0 = s_waitrequest; eRd0 = s_readdata; eGrant = 2'b01;
        end else begin
            eAddr = m1_address; eWd = m1_writedata; eBe = m1_byteenable;
            eWr = m1_write; eRd = m1_read && !m1_write;
            eW1 = s_waitrequest; eRd1 = s_readdata; eGrant = 2'b10;
        end
        checkOutput({tag, ".s_read"}, 32'(s_read), 32'(eRd));
        checkOutput({tag, ".s_write"}, 32'(s_write), 32'(eWr));
        if (!mAbort) begin
            checkOutput({tag, ".s_address"}, s_address, eAddr);
            checkOutput({tag, ".s_writedata"}, s_writedata, eWd);
            checkOutput({tag, ".s_byteenable"}, 32'(s_byteenable), 32'(eBe));
            checkOutput({tag, ".grant"}, 32'(grant), 32'(eGrant));
        end
        checkOutput({tag, ".m0_waitrequest"}, 32'(m0_waitrequest), 32'(eW0));
        checkOutput({tag, ".m1_waitrequest"}, 32'(m1_waitrequest), 32'(eW1));
        checkOutput({tag, ".m0_readdata"}, m0_readdata, eRd0);
        checkOutput({tag, ".m1_readdata"}, m1_readdata, eRd1);
        checkOutput({tag, ".bus_timeout"}, 32'(bus_timeout), 32'(mSticky));
        expW0 = eW0;
        expW1 = eW1;
    endtask

    // One transfer per grant, one idle cycle between grants, abort after TIMEOUT stalls
    task automatic modelAdvance();
        bit r0, r1, rOwn;
        r0 = m0_read | m0_write;
        r1 = m1_read | m1_write;
        rOwn = (mOwner == 0) ? r0 : r1;
        if (mAbort) begin
            mSticky = 1'b1;
            mLast   = mOwner;
            mOwner  = -1;
            mAbort  = 1'b0;
            mStall  = 0;
        end else if (mOwner < 0) begin
            if (r0 && r1) mOwner = 1 - mLast;
            else if (r0) mOwner = 0;
            else if (r1) mOwner = 1;
        end else if (!rOwn) begin
            mOwner = -1;
            mStall = 0;
        end else if (!s_waitrequest) begin
            mLast  = mOwner;
            mOwner = -1;
            mStall = 0;
        end else if (mStall == TIMEOUT - 1) begin
            mAbort = 1'b1;
        end else begin
            mStall++;
        end
    endtask

    task automatic settle(input string tag);
        #1;
        checkAll(tag);
    endtask

    task automatic endCycle();
        modelAdvance();
        @(negedge clk);
    endtask

    initial begin
        #200000;
        $display("[TB] FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "[TB] watchdog");
    end

    initial begin
        int op0, op1, stuckLeft, abortCycle, m1DoneCycle;
        bit m0Pend, m1Pend;
        logic [31:0] a0, d0, a1, d1;
        logic [3:0]  b0, b1;
        logic        sw;

        reset = 1'b0;
        applyStimulus(0, 0, 0, 0, 0, 0, 0, 0, 1'b0, 0);
        modelReset();
        repeat (2) @(negedge clk);
        settle("reset");
        reset = 1'b1;
        @(negedge clk);

        // Reset pulled in the middle of an m0 transfer
        applyStimulus(1, 32'h0, 0, 4'hF, 0, 0, 0, 0, 1'b1, 32'h5);
        settle("s1.idle");
        endCycle();
        applyStimulus(1, 32'h0, 0, 4'hF, 0, 0, 0, 0, 1'b1, 32'h5);
        settle("s1.own");
        checkOutput("s1.s_read_owned", 32'(s_read), 32'd1);
        #1 reset = 1'b0;
        #1;
        checkOutput("s1.rst.s_read", 32'(s_read), 32'd0);
        checkOutput("s1.rst.s_write", 32'(s_write), 32'd0);
        checkOutput("s1.rst.grant", 32'(grant), 32'd0);
        checkOutput("s1.rst.bus_timeout", 32'(bus_timeout), 32'd0);
        modelReset();
        @(negedge clk);
        reset = 1'b1;

        $display("[TB] alternating grants");
        for (int i = 0; i < 6; i++) begin
            applyStimulus(1, 32'h100, 0, 4'hF, 2, 32'h20, 32'hDEADBEEF, 4'hF, 1'b0, 32'h11110000 + i);
            settle("alt");
            checkOutput("alt.grant_seq", 32'(grant), 32'(altGrant[i]));
            if (altGrant[i] == 2'b10) begin
                checkOutput("alt.m1_s_write", 32'(s_write), 32'd1);
                checkOutput("alt.m1_s_writedata", s_writedata, 32'hDEADBEEF);
                checkOutput("alt.m1_s_address", s_address, 32'h20);
            end else begin
                checkOutput("alt.no_s_write", 32'(s_write), 32'd0);
            end
            endCycle();
        end

        $display("[TB] single m0 read");
        applyStimulus(1, 32'h4, 0, 4'hF, 0, 0, 0, 0, 1'b0, 32'h24020010);
        settle("rd.idle");
        checkOutput("rd.idle.grant", 32'(grant), 32'd0);
        endCycle();
        applyStimulus(1, 32'h4, 0, 4'hF, 0, 0, 0, 0, 1'b0, 32'h24020010);
        settle("rd.own");
        checkOutput("rd.own.grant", 32'(grant), 32'b01);
        checkOutput("rd.own.m0_readdata", m0_readdata, 32'h24020010);
        checkOutput("rd.own.m0_waitrequest", 32'(m0_waitrequest), 32'd0);
        checkOutput("rd.own.m1_readdata", m1_readdata, 32'd0);
        endCycle();

        $display("[TB] slave wait states on m1 write");
        for (int c = 0; c < 5; c++) begin
            applyStimulus(1, 32'h8, 0, 4'hF, 2, 32'h30, 32'h0BADF00D, 4'h3,
                          1'((c >= 1) && (c <= 3)), 32'h0);
            settle("ws");
            checkOutput("ws.m0_waitrequest", 32'(m0_waitrequest), 32'd1);
            checkOutput("ws.m1_waitrequest", 32'(m1_waitrequest), 32'(c < 4));
            endCycle();
        end
        for (int c = 0; c < 2; c++) begin
            applyStimulus(1, 32'h8, 0, 4'hF, 0, 0, 0, 0, 1'b0, 32'h77);
            settle("ws.m0");
            checkOutput("ws.m0_served", 32'(m0_waitrequest), 32'(c == 0));
            endCycle();
        end
        checkOutput("ws.no_timeout", 32'(bus_timeout), 32'd0);

        $display("[TB] stuck slave timeout");
        m0Pend = 1'b1; m1Pend = 1'b1; abortCycle = -1; m1DoneCycle = -1;
        for (int c = 0; c < 20; c++) begin
            applyStimulus(m0Pend ? 1 : 0, 32'h40, 0, 4'hF,
                          (m1Pend && c >= 2) ? 2 : 0, 32'h80, 32'hCAFEF00D, 4'hF,
                          1'(abortCycle < 0), 32'h12345678);
            settle("to");
            if (m0Pend && !m0_waitrequest) begin
                abortCycle = c;
                m0Pend = 1'b0;
                checkOutput("to.abort_rdata", m0_readdata, ABORT);
            end else if (m1Pend && c >= 2 && !m1_waitrequest) begin
                m1DoneCycle = c;
                m1Pend = 1'b0;
                checkOutput("to.sticky_after", 32'(bus_timeout), 32'd1);
            end
            endCycle();
        end
        checkOutput("to.abort_cycle", 32'(abortCycle), 32'd9);
        checkOutput("to.m1_done_cycle", 32'(m1DoneCycle), 32'd11);
        checkOutput("to.sticky_held", 32'(bus_timeout), 32'd1);

        $display("[TB] random traffic");
        op0 = 0; op1 = 0; stuckLeft = 0;
        a0 = 0; d0 = 0; b0 = 0; a1 = 0; d1 = 0; b1 = 0;
        for (int cyc = 0; cyc < 600; cyc++) begin
            if (cyc == 300) begin
                reset = 1'b0;
                #1;
                checkOutput("rand.rst.grant", 32'(grant), 32'd0);
                checkOutput("rand.rst.s_read", 32'(s_read), 32'd0);
                checkOutput("rand.rst.s_write", 32'(s_write), 32'd0);
                checkOutput("rand.rst.bus_timeout", 32'(bus_timeout), 32'd0);
                modelReset();
                op0 = 0; op1 = 0;
                @(negedge clk);
                reset = 1'b1;
            end
            if (op0 == 0 && $urandom_range(0, 2) == 0) begin
                op0 = $urandom_range(1, 2); a0 = $urandom & 32'hFFFF_FFFC;
                d0 = $urandom; b0 = 4'($urandom_range(1, 15));
            end else if (op0 != 0 && $urandom_range(0, 39) == 0) begin
                op0 = 0;
            end
            if (op1 == 0 && $urandom_range(0, 2) == 0) begin
                op1 = $urandom_range(1, 2); a1 = $urandom & 32'hFFFF_FFFC;
                d1 = $urandom; b1 = 4'($urandom_range(1, 15));
            end else if (op1 != 0 && $urandom_range(0, 39) == 0) begin
                op1 = 0;
            end
            if (stuckLeft == 0 && $urandom_range(0, 59) == 0) stuckLeft = 12;
            sw = (stuckLeft > 0) ? 1'b1 : 1'($urandom_range(0, 2) == 0);
            if (stuckLeft > 0) stuckLeft--;
            applyStimulus(op0, a0, d0, b0, op1, a1, d1, b1, sw, $urandom);
            settle("rand");
            if (op0 != 0 && !expW0) op0 = 0;
            if (op1 != 0 && !expW1) op1 = 0;
            endCycle();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
